// File: rtl/stb_gen_ext.sv
// Strobe generator: averages the sig_i period over 2^AVG_LOG2 periods, then emits a phased strobe train.
// Optional build macro STB_GEN_EXT_GATE_EN gates stb_o with oe_i and ~err_o.
module stb_gen_ext #(
    parameter int unsigned T_CNT_WIDTH    = 32,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned W_WIDTH        = 16,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter logic [T_CNT_WIDTH-1:0] T_CNT_RST = {T_CNT_WIDTH{1'b0}}
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sig_i,
    input  logic                   run_i,
    input  logic                   stop_i,
    input  logic                   mode_i,
    input  logic [W_WIDTH-1:0]     burst_len_i,
    input  logic [W_WIDTH-1:0]     offset_i,
    input  logic [W_WIDTH-1:0]     width_i,
    input  logic                   oe_i,
    output logic                   stb_o,
    output logic                   rdy_o,
    output logic                   busy_o,
    output logic                   err_o,
    output logic [T_CNT_WIDTH-1:0] stb_period_o,
    output logic [W_WIDTH-1:0]     stb_cnt_o
);
    localparam int unsigned FRAC_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int unsigned ECNT_W = AVG_LOG2 + 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ECNT_W-1:0]      ECNT_LAST = ECNT_W'((32'd1 << AVG_LOG2) - 32'd1);
    localparam logic [TO_W-1:0]        TO_LAST   = TO_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [T_CNT_WIDTH-1:0] T_ONE     = T_CNT_WIDTH'(32'd1);
    localparam logic [T_CNT_WIDTH-1:0] T_TWO     = T_CNT_WIDTH'(32'd2);
    localparam logic [W_WIDTH-1:0]     W_ZERO    = {W_WIDTH{1'b0}};
    localparam logic [W_WIDTH-1:0]     W_ONE     = W_WIDTH'(32'd1);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SKIP       = 4'd1,
        ST_MEAS_START = 4'd2,
        ST_MEAS       = 4'd3,
        ST_CALC       = 4'd4,
        ST_CHECK      = 4'd5,
        ST_WAIT_RISE  = 4'd6,
        ST_HIGH       = 4'd7,
        ST_DONE       = 4'd8
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [SYNC_STAGES-1:0]  sig_sync_r, run_sync_r, stop_sync_r;
    logic                    sig_d_r, run_d_r, stop_d_r;
    logic                    sig_edge_s, run_edge_s, stop_edge_s;
    logic [T_CNT_WIDTH-1:0]  t_cnt_r, t_start_r, t_end_r, period_r, next_rise_r;
    logic [T_CNT_WIDTH-1:0]  t_start_nxt_s, t_end_nxt_s, period_nxt_s, next_rise_nxt_s, sum_s;
    logic [FRAC_W-1:0]       frac_r, acc_r, frac_nxt_s, acc_nxt_s;
    logic [FRAC_W:0]         acc_sum_s;
    logic [W_WIDTH-1:0]      hi_cnt_r, burst_r, offset_r, width_r, cnt_r;
    logic [W_WIDTH-1:0]      hi_cnt_nxt_s, burst_nxt_s, offset_nxt_s, width_nxt_s, cnt_nxt_s, burst_eff_s;
    logic [ECNT_W-1:0]       edge_cnt_r, edge_cnt_nxt_s;
    logic [TO_W-1:0]         to_cnt_r, to_cnt_nxt_s;
    logic                    mode_r, stb_r, rdy_r, busy_r, err_r;
    logic                    mode_nxt_s, stb_nxt_s, rdy_nxt_s, busy_nxt_s, err_nxt_s, cfg_bad_s;

    // Input synchronisers plus previous-value flops for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_sync_r  <= {SYNC_STAGES{1'b0}};
            run_sync_r  <= {SYNC_STAGES{1'b0}};
            stop_sync_r <= {SYNC_STAGES{1'b0}};
            sig_d_r     <= 1'b0;
            run_d_r     <= 1'b0;
            stop_d_r    <= 1'b0;
        end else begin
            sig_sync_r  <= SYNC_STAGES'({sig_sync_r, sig_i});
            run_sync_r  <= SYNC_STAGES'({run_sync_r, run_i});
            stop_sync_r <= SYNC_STAGES'({stop_sync_r, stop_i});
            sig_d_r     <= sig_sync_r[SYNC_STAGES-1];
            run_d_r     <= run_sync_r[SYNC_STAGES-1];
            stop_d_r    <= stop_sync_r[SYNC_STAGES-1];
        end
    end

    assign sig_edge_s  = sig_sync_r[SYNC_STAGES-1] & ~sig_d_r;
    assign run_edge_s  = run_sync_r[SYNC_STAGES-1] & ~run_d_r;
    assign stop_edge_s = stop_sync_r[SYNC_STAGES-1] & ~stop_d_r;

    assign sum_s       = t_end_r - t_start_r;
    assign acc_sum_s   = {1'b0, acc_r} + {1'b0, frac_r};
    assign burst_eff_s = (burst_r == W_ZERO) ? W_ONE : burst_r;
    assign cfg_bad_s   = (period_r < T_TWO) || (width_r == W_ZERO) ||
                         (T_CNT_WIDTH'(width_r) >= period_r) || (T_CNT_WIDTH'(offset_r) >= period_r);

    // Next-state and next-register logic; stop overrides every non-idle state.
    always_comb begin
        state_nxt_s     = state_r;
        t_start_nxt_s   = t_start_r;
        t_end_nxt_s     = t_end_r;
        period_nxt_s    = period_r;
        frac_nxt_s      = frac_r;
        acc_nxt_s       = acc_r;
        next_rise_nxt_s = next_rise_r;
        hi_cnt_nxt_s    = hi_cnt_r;
        edge_cnt_nxt_s  = edge_cnt_r;
        to_cnt_nxt_s    = to_cnt_r;
        mode_nxt_s      = mode_r;
        burst_nxt_s     = burst_r;
        offset_nxt_s    = offset_r;
        width_nxt_s     = width_r;
        stb_nxt_s       = stb_r;
        rdy_nxt_s       = rdy_r;
        err_nxt_s       = err_r;
        cnt_nxt_s       = cnt_r;
        if (stop_edge_s && (state_r != ST_IDLE)) begin
            state_nxt_s = ST_IDLE;
            stb_nxt_s   = 1'b0;
            rdy_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run_edge_s && !stop_edge_s) begin
                        mode_nxt_s   = mode_i;
                        burst_nxt_s  = burst_len_i;
                        offset_nxt_s = offset_i;
                        width_nxt_s  = width_i;
                        err_nxt_s    = 1'b0;
                        cnt_nxt_s    = W_ZERO;
                        to_cnt_nxt_s = {TO_W{1'b0}};
                        state_nxt_s  = ST_SKIP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SKIP, ST_MEAS_START, ST_MEAS: begin
                    if (sig_edge_s) begin
                        to_cnt_nxt_s = {TO_W{1'b0}};
                        if (state_r == ST_SKIP) begin
                            state_nxt_s = ST_MEAS_START;
                        end else if (state_r == ST_MEAS_START) begin
                            t_start_nxt_s  = t_cnt_r;
                            edge_cnt_nxt_s = {ECNT_W{1'b0}};
                            state_nxt_s    = ST_MEAS;
                        end else if (edge_cnt_r == ECNT_LAST) begin
                            t_end_nxt_s = t_cnt_r;
                            state_nxt_s = ST_CALC;
                        end else begin
                            edge_cnt_nxt_s = edge_cnt_r + ECNT_W'(32'd1);
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        to_cnt_nxt_s = to_cnt_r + TO_W'(32'd1);
                    end
                end
                ST_CALC: begin
                    period_nxt_s = sum_s >> AVG_LOG2;
                    frac_nxt_s   = (AVG_LOG2 == 0) ? {FRAC_W{1'b0}} : sum_s[FRAC_W-1:0];
                    state_nxt_s  = ST_CHECK;
                end
                ST_CHECK: begin
                    if (cfg_bad_s) begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        next_rise_nxt_s = t_end_r + period_r + T_CNT_WIDTH'(offset_r);
                        acc_nxt_s       = {FRAC_W{1'b0}};
                        rdy_nxt_s       = 1'b1;
                        state_nxt_s     = ST_WAIT_RISE;
                    end
                end
                ST_WAIT_RISE: begin
                    // Fractional carry keeps the long-run mean period exact.
                    if (t_cnt_r == next_rise_r) begin
                        stb_nxt_s       = 1'b1;
                        hi_cnt_nxt_s    = width_r - W_ONE;
                        cnt_nxt_s       = cnt_r + W_ONE;
                        acc_nxt_s       = acc_sum_s[FRAC_W-1:0];
                        next_rise_nxt_s = next_rise_r + period_r + T_CNT_WIDTH'(acc_sum_s[FRAC_W]);
                        state_nxt_s     = ST_HIGH;
                    end else begin
                        state_nxt_s = ST_WAIT_RISE;
                    end
                end
                ST_HIGH: begin
                    if (hi_cnt_r == W_ZERO) begin
                        stb_nxt_s   = 1'b0;
                        state_nxt_s = (mode_r && (cnt_r == burst_eff_s)) ? ST_DONE : ST_WAIT_RISE;
                    end else begin
                        hi_cnt_nxt_s = hi_cnt_r - W_ONE;
                    end
                end
                ST_DONE: begin
                    rdy_nxt_s   = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    stb_nxt_s   = 1'b0;
                    rdy_nxt_s   = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State, datapath and output registers; t_cnt free-runs outside reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            t_cnt_r     <= T_CNT_RST;
            t_start_r   <= {T_CNT_WIDTH{1'b0}};
            t_end_r     <= {T_CNT_WIDTH{1'b0}};
            period_r    <= {T_CNT_WIDTH{1'b0}};
            next_rise_r <= {T_CNT_WIDTH{1'b0}};
            frac_r      <= {FRAC_W{1'b0}};
            acc_r       <= {FRAC_W{1'b0}};
            hi_cnt_r    <= W_ZERO;
            edge_cnt_r  <= {ECNT_W{1'b0}};
            to_cnt_r    <= {TO_W{1'b0}};
            mode_r      <= 1'b0;
            burst_r     <= W_ZERO;
            offset_r    <= W_ZERO;
            width_r     <= W_ZERO;
            stb_r       <= 1'b0;
            rdy_r       <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            cnt_r       <= W_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            t_cnt_r     <= t_cnt_r + T_ONE;
            t_start_r   <= t_start_nxt_s;
            t_end_r     <= t_end_nxt_s;
            period_r    <= period_nxt_s;
            next_rise_r <= next_rise_nxt_s;
            frac_r      <= frac_nxt_s;
            acc_r       <= acc_nxt_s;
            hi_cnt_r    <= hi_cnt_nxt_s;
            edge_cnt_r  <= edge_cnt_nxt_s;
            to_cnt_r    <= to_cnt_nxt_s;
            mode_r      <= mode_nxt_s;
            burst_r     <= burst_nxt_s;
            offset_r    <= offset_nxt_s;
            width_r     <= width_nxt_s;
            stb_r       <= stb_nxt_s;
            rdy_r       <= rdy_nxt_s;
            busy_r      <= busy_nxt_s;
            err_r       <= err_nxt_s;
            cnt_r       <= cnt_nxt_s;
        end
    end

`ifdef STB_GEN_EXT_GATE_EN
    assign stb_o = stb_r & oe_i & ~err_r;
`else
    logic unused_oe_s;
    assign unused_oe_s = oe_i;
    assign stb_o       = stb_r;
`endif
    assign rdy_o        = rdy_r;
    assign busy_o       = busy_r;
    assign err_o        = err_r;
    assign stb_period_o = period_r;
    assign stb_cnt_o    = cnt_r;
endmodule

// File: tb/tb_stb_gen_ext.sv
// Self-checking bench for stb_gen_ext: randomized sig periods against an arithmetic strobe-schedule model.
module tb_stb_gen_ext;
    localparam int A   = 2;
    localparam int S   = 2;
    localparam int TO  = 1000;
    localparam int DEN = 1 << A;
    localparam int NE  = 2 + DEN;   // skipped edge, start edge, then DEN measured edges
    localparam int LAT = S + 1;     // sig_i drive cycle to the cycle t_cnt is sampled, plus register stage

    logic        clk_i = 1'b0;
    logic        rst_i, sig_i, run_i, stop_i, mode_i, oe_i;
    logic [15:0] burst_len_i, offset_i, width_i;
    logic        stb_o, rdy_o, busy_o, err_o;
    logic [31:0] stb_period_o;
    logic [15:0] stb_cnt_o;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int per_a [0:NE-2];
    int last_edge;

    // t_cnt starts 800 cycles before wrap so the first strobe train crosses it.
    stb_gen_ext #(.TIMEOUT_CYCLES(TO), .T_CNT_RST(32'hFFFF_FCE0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sig_i(sig_i), .run_i(run_i), .stop_i(stop_i),
        .mode_i(mode_i), .burst_len_i(burst_len_i), .offset_i(offset_i), .width_i(width_i),
        .oe_i(oe_i), .stb_o(stb_o), .rdy_o(rdy_o), .busy_o(busy_o), .err_o(err_o),
        .stb_period_o(stb_period_o), .stb_cnt_o(stb_cnt_o));

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic at_cyc(input int t);
        do @(negedge clk_i); while (cyc < t);
    endtask

    task automatic pulse_run();
        run_i = 1'b1; tick(4); run_i = 1'b0; tick(1);
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1; tick(4); stop_i = 1'b0; tick(1);
    endtask

    task automatic set_per(input int b, input int jit);
        for (int i = 0; i < NE - 1; i++) per_a[i] = b + $urandom_range(jit, 0);
    endtask

    task automatic drive_edges();
        for (int i = 0; i < NE; i++) begin
            sig_i = 1'b1;
            last_edge = cyc;
            tick(2);
            sig_i = 1'b0;
            if (i < NE - 1) tick(per_a[i] - 2);
        end
    endtask

    // k-th rise = first rise + floor(k * sum / 2^A): exact mean period, no drift.
    function automatic int rise(input int base, input int sum, input int k);
        return base + (k * sum) / DEN;
    endfunction

    task automatic set_cfg(input int off, input int w, input int md, input int bl);
        offset_i = 16'(off); width_i = 16'(w); mode_i = md[0]; burst_len_i = 16'(bl);
    endtask

    task automatic train(input int off, input int w, input int md, input int bl, input int nstb);
        int sum, p, lim, base, end_c, k;
        logic exp_stb;
        sum = 0;
        for (int i = 1; i < NE - 1; i++) sum += per_a[i];
        p = sum / DEN;
        lim = md ? ((bl == 0) ? 1 : bl) : nstb;
        set_cfg(off, w, md, bl);
        pulse_run();
        drive_edges();
        base = last_edge + LAT + p + off;
        end_c = md ? rise(base, sum, lim - 1) + w + 20 : rise(base, sum, lim) - 1;
        k = 0;
        while (cyc < end_c) begin
            @(negedge clk_i);
            while (k < lim && rise(base, sum, k) + w <= cyc) k++;
            exp_stb = (k < lim) && (cyc >= rise(base, sum, k));
            check_val("stb", 64'(stb_o), 64'(exp_stb));
            if (k < lim && cyc == rise(base, sum, k)) begin
                check_val("rdy", 64'(rdy_o), 64'd1);
                check_val("period", 64'(stb_period_o), 64'(p));
            end
        end
        check_val("stb_cnt", 64'(stb_cnt_o), 64'(lim));
        if (md == 0) begin
            tick(1);
            pulse_stop();
            tick(2);
        end else begin
            tick(1);
        end
        @(negedge clk_i);
        check_val("end_busy", 64'(busy_o), 64'd0);
        check_val("end_rdy", 64'(rdy_o), 64'd0);
        check_val("end_stb", 64'(stb_o), 64'd0);
        check_val("end_period", 64'(stb_period_o), 64'(p));
        tick(1);
    endtask

    task automatic bad_cfg(input int off, input int w);
        int seen;
        seen = 0;
        set_per(100, 0);
        set_cfg(off, w, 0, 0);
        pulse_run();
        drive_edges();
        repeat (300) begin
            @(negedge clk_i);
            if (stb_o) seen = 1;
        end
        check_val("bad_no_stb", 64'(seen), 64'd0);
        check_val("bad_err", 64'(err_o), 64'd1);
        check_val("bad_busy", 64'(busy_o), 64'd0);
        check_val("bad_rdy", 64'(rdy_o), 64'd0);
        check_val("bad_period", 64'(stb_period_o), 64'd100);
        tick(1);
    endtask

    task automatic abort_in_high(input int use_rst);
        int found, s;
        found = 0;
        set_per(50, 0);
        set_cfg(3, 20, 0, 0);
        pulse_run();
        drive_edges();
        for (int i = 0; i < 500 && found == 0; i++) begin
            @(negedge clk_i);
            if (stb_o) found = 1;
        end
        check_val("stb_seen", 64'(found), 64'd1);
        @(posedge clk_i); #1;
        s = cyc;
        if (use_rst != 0) begin
            rst_i = 1'b1;
            at_cyc(s + 1);
            check_val("rst_stb", 64'(stb_o), 64'd0);
            check_val("rst_busy", 64'(busy_o), 64'd0);
            check_val("rst_period", 64'(stb_period_o), 64'd0);
            check_val("rst_cnt", 64'(stb_cnt_o), 64'd0);
            tick(1);
            rst_i = 1'b0;
        end else begin
            stop_i = 1'b1;
            at_cyc(s + S);
            check_val("pre_stop_stb", 64'(stb_o), 64'd1);
            at_cyc(s + S + 1);
            check_val("stop_stb", 64'(stb_o), 64'd0);
            check_val("stop_busy", 64'(busy_o), 64'd0);
            check_val("stop_rdy", 64'(rdy_o), 64'd0);
            check_val("stop_period", 64'(stb_period_o), 64'd50);
            tick(1);
            stop_i = 1'b0;
        end
        tick(3);
    endtask

    task automatic timeout_case();
        int c, seen;
        seen = 0;
        set_cfg(10, 5, 0, 0);
        @(posedge clk_i); #1;
        c = cyc;
        run_i = 1'b1; tick(4); run_i = 1'b0;
        at_cyc(c + LAT + TO - 10);
        check_val("to_err_early", 64'(err_o), 64'd0);
        while (cyc < c + LAT + TO + 10) begin
            @(negedge clk_i);
            if (stb_o) seen = 1;
        end
        check_val("to_no_stb", 64'(seen), 64'd0);
        check_val("to_err", 64'(err_o), 64'd1);
        check_val("to_busy", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;
        c = cyc;
        run_i = 1'b1;
        at_cyc(c + S + 2);
        check_val("to_err_clr", 64'(err_o), 64'd0);
        check_val("to_busy_rerun", 64'(busy_o), 64'd1);
        tick(2);
        run_i = 1'b0;
        pulse_stop();
        @(negedge clk_i);
        check_val("to_stop_busy", 64'(busy_o), 64'd0);
        tick(1);
    endtask

    initial begin
        rst_i = 1'b1; sig_i = 1'b0; run_i = 1'b0; stop_i = 1'b0; oe_i = 1'b1;
        set_cfg(0, 0, 0, 0);
        tick(3);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_val("rst_stb_o", 64'(stb_o), 64'd0);
        check_val("rst_rdy_o", 64'(rdy_o), 64'd0);
        check_val("rst_busy_o", 64'(busy_o), 64'd0);
        check_val("rst_err_o", 64'(err_o), 64'd0);
        check_val("rst_period_o", 64'(stb_period_o), 64'd0);
        check_val("rst_cnt_o", 64'(stb_cnt_o), 64'd0);
        tick(1);

        // Period 100, offset 10, width 5, continuous; runs across the t_cnt wrap.
        set_per(100, 0);
        train(10, 5, 0, 0, 30);

        // Alternating 102/103 periods: sum 410 -> 102 with fraction 2.
        per_a[0] = 103; per_a[1] = 102; per_a[2] = 103; per_a[3] = 102; per_a[4] = 103;
        train(7, 10, 0, 0, 200);

        // Burst of three.
        set_per(60, 0);
        train(5, 8, 1, 3, 0);

        for (int t = 0; t < 6; t++) begin
            int b, w, off, md, bl;
            b = $urandom_range(150, 12);
            set_per(b, 3);
            w = $urandom_range(b - 1, 1);
            off = $urandom_range(b - 1, 0);
            md = $urandom_range(1, 0);
            bl = $urandom_range(4, 0);
            train(off, w, md, bl, 8);
        end

        timeout_case();
        bad_cfg(10, 100);
        bad_cfg(100, 5);
        abort_in_high(0);
        abort_in_high(1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/stb_gen_ext.md
Name: stb_gen_ext

Overview:
Parametrised successor of the single-shot strobe generator in the measure unit. Measures the period of sig_i averaged over 2^AVG_LOG2 periods, with fractional-remainder tracking. It then emits a strobe train with programmable phase offset and pulse width, in continuous or burst mode. A no-edge timeout and config sanity checks report errors. Sits between the comparator input and the sampling/DAC trigger logic of the calibration SoC.

Parameters:
T_CNT_WIDTH, 32, width of free-running timestamp counter and period output
AVG_LOG2, 2, log2 of number of periods averaged (0..8)
W_WIDTH, 16, width of offset_i / width_i / burst_len_i / stb_cnt_o
SYNC_STAGES, 2, synchroniser depth for sig_i, run_i, stop_i
TIMEOUT_CYCLES, 1048576, max clk cycles between sig edges during measurement

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
sig_i  in  1  async measured signal
run_i  in  1  async; rising edge (after sync) starts measurement
stop_i  in  1  async; rising edge (after sync) aborts to IDLE
mode_i  in  1  0 = continuous, 1 = burst; sampled at run edge
burst_len_i  in  W_WIDTH  strobes per burst; sampled at run edge
offset_i  in  W_WIDTH  strobe rise delay after reference edge; sampled at run edge
width_i  in  W_WIDTH  strobe high time in cycles; sampled at run edge
oe_i  in  1  output enable (see Optional Feature)
stb_o  out  1  strobe
rdy_o  out  1  period valid, strobing active
busy_o  out  1  state != IDLE
err_o  out  1  sticky error, cleared at next run edge
stb_period_o  out  T_CNT_WIDTH  integer part of averaged period
stb_cnt_o  out  W_WIDTH  strobes emitted since run edge; wraps modulo 2^W_WIDTH

Behaviour:
- One clock; synchronous active-high reset rst_i. Reset mid-operation forces IDLE on the next edge.
- Reset values: stb_o=0, rdy_o=0, busy_o=0, err_o=0, stb_period_o=0, stb_cnt_o=0.
- sig/run/stop each pass through SYNC_STAGES flops, then a 1-cycle edge detector. All timestamps refer to synced posedges.
- t_cnt is a free-running T_CNT_WIDTH counter. All comparisons are equality and all differences are modulo 2^T_CNT_WIDTH, so wrap-around is transparent.
- State machine:
  - IDLE: on run edge, latch config, clear err_o and stb_cnt_o, go to SKIP.
  - SKIP: wait for first sig edge and discard it (partial period), then go to MEAS_START.
  - MEAS_START: on next edge, t_start <= t_cnt; go to MEAS.
  - MEAS: count 2^AVG_LOG2 further edges. On the last one, t_end <= t_cnt; go to CALC.
  - CALC (1 cycle): sum = t_end - t_start. Then stb_period_o <= sum >> AVG_LOG2, frac <= sum[AVG_LOG2-1:0].
  - CHECK (1 cycle): go to IDLE with err_o=1 if any of:
    - stb_period_o < 2
    - width_i == 0
    - width_i >= stb_period_o
    - offset_i >= stb_period_o
    Otherwise set next_rise = t_end + stb_period_o + offset_i, acc=0, rdy_o=1, go to WAIT_RISE.
  - WAIT_RISE: when t_cnt == next_rise, set stb_o=1, load the fall count, increment stb_cnt_o. Schedule the next rise: next_rise += stb_period_o + carry, where {carry, acc} = acc + frac (AVG_LOG2-bit accumulator). Go to HIGH.
  - HIGH: stb_o stays 1 for exactly width_i cycles, then drops to 0.
    - Continuous mode: go to WAIT_RISE.
    - Burst mode: if stb_cnt_o == burst_len_i, go to DONE; otherwise go to WAIT_RISE.
  - DONE: rdy_o=0, go to IDLE. A burst_len_i of 0 is treated as 1.
- Timeout: in SKIP, MEAS_START or MEAS, if TIMEOUT_CYCLES pass without a sig edge, set err_o=1 and go to IDLE.
- stop edge in any non-IDLE state: go to IDLE, stb_o=0 immediately (next cycle), rdy_o=0; stb_period_o is held.
- A run edge while not IDLE is ignored. If run and stop edges coincide in IDLE, stop wins and the block stays IDLE.
- stb_period_o holds its last value until the next CALC.
- No sig activity is required after measurement; strobes run from t_cnt only.

Optional Feature:
STB_GEN_EXT_GATE_EN:
- Defined: stb_o = internal strobe & oe_i & ~err_o. Gating is combinational on the registered strobe. stb_cnt_o still counts internal strobes.
- Undefined: oe_i is ignored and stb_o = internal strobe register.

Test Plan:
1. sig period 100, AVG_LOG2=2, offset 10, width 5, continuous -> stb_period_o=100. First rise 110 cycles after the last measured synced edge, then rises every 100 cycles, each 5 cycles high; rdy_o=1.
2. sig period alternating 102/103 -> sum 410, stb_period_o=102, frac=2. Rise intervals repeat 102,103,102,103 with no cumulative drift over 1000 strobes.
3. Burst mode, burst_len_i=3 -> exactly 3 strobes, stb_cnt_o=3, rdy_o falls, busy_o=0 afterwards.
4. sig held low after run edge, TIMEOUT_CYCLES=1000 -> err_o=1 about 1000 cycles after entering SKIP, stb_o never 1. Next run edge clears err_o.
5. width_i=100 with period 100 -> err_o=1 after CHECK, no strobe. Repeat with offset_i=100 -> same result.
6. Assert rst_i while stb_o=1, and separately stop_i while in HIGH -> stb_o=0 next cycle, busy_o=0. Preset t_cnt near 2^32-50 -> strobe spacing is unchanged across wrap.
